fb_mem_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM between the arm data port and a display fetch engine.

---
 rtl/fb_mem_arbiter_if.sv | 39 +++
 rtl/fb_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle between the framebuffer arbiter (slave side) and its environment:
// CPU data port, display pixel port and the single-port RAM.
interface fb_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // CPU handshake: cpu_req/cpu_we/cpu_addr/cpu_wdata are held stable until the
  // cycle cpu_ready is high; that cycle is the transfer. Reads return on
  // cpu_rvalid/cpu_rdata a fixed RD_LAT cycles later, with no back-pressure.
  logic              enable;
  logic              frame_start;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              pix_req;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  enable, frame_start, cpu_req, cpu_we, cpu_addr, cpu_wdata, pix_req, mem_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, pix_data, pix_valid, underrun,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output enable, frame_start, cpu_req, cpu_we, cpu_addr, cpu_wdata, pix_req, mem_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, pix_data, pix_valid, underrun,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: display prefetch into a pixel FIFO vs CPU accesses.
// Define FB_ARB_STATS_EN to add the stall_cnt / underrun_cnt statistics ports.
module fb_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FB_WORDS   = 65536,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                clk,
  input  logic                reset,
  fb_mem_arbiter_if.slave     bus,
  output logic [1:0]          state_o
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [15:0]         underrun_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CR_W  = PTR_W + 2;
  localparam int FA_W  = $clog2(FB_WORDS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q;
  logic [FA_W-1:0]   fetch_addr_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic              epoch_q;
  logic [RD_LAT-1:0] pf_q, pe_q, pc_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] pix_data_q;
  logic              pix_valid_q, underrun_q;

  logic              restart, fetch_elig, urgent, fetch_gnt, cpu_gnt;
  logic              push, pop, empty_pop;
  logic [CR_W-1:0]   inflight, credit;

  // Credit counts only current-epoch fetches so stale returns never block refill.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pf_q[i] && (pe_q[i] == epoch_q)) inflight = inflight + CR_W'(1);
    end
    credit     = CR_W'(count_q) + inflight;
    restart    = bus.enable && bus.frame_start;
    fetch_elig = reset && (state_q == FETCH) && !restart && (credit < CR_W'(FIFO_DEPTH));
    urgent     = credit < CR_W'(LOW_WATER);
    fetch_gnt  = fetch_elig && (urgent || !bus.cpu_req);
    cpu_gnt    = reset && bus.cpu_req && !(fetch_elig && urgent);
    push       = pf_q[RD_LAT-1] && (pe_q[RD_LAT-1] == epoch_q) && !restart;
    pop        = bus.pix_req && (count_q != '0);
    empty_pop  = bus.pix_req && (count_q == '0);
  end

  always_comb begin
    bus.cpu_ready  = cpu_gnt;
    bus.mem_we     = cpu_gnt && bus.cpu_we;
    bus.mem_wdata  = (cpu_gnt && bus.cpu_we) ? bus.cpu_wdata : '0;
    if (cpu_gnt)        bus.mem_addr = bus.cpu_addr;
    else if (fetch_gnt) bus.mem_addr = ADDR_W'(fetch_addr_q);
    else                bus.mem_addr = mem_addr_q;
    bus.cpu_rvalid = pc_q[RD_LAT-1];
    bus.cpu_rdata  = pc_q[RD_LAT-1] ? bus.mem_rdata : '0;
    bus.pix_data   = pix_data_q;
    bus.pix_valid  = pix_valid_q;
    bus.underrun   = underrun_q;
    state_o        = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      epoch_q      <= 1'b0;
      pf_q         <= '0;
      pe_q         <= '0;
      pc_q         <= '0;
      mem_addr_q   <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      pf_q <= RD_LAT'({pf_q, fetch_gnt});
      pe_q <= RD_LAT'({pe_q, epoch_q});
      pc_q <= RD_LAT'({pc_q, cpu_gnt && !bus.cpu_we});
      if (cpu_gnt || fetch_gnt) mem_addr_q <= bus.mem_addr;
      pix_valid_q <= pop;
      if (pop) pix_data_q <= fifo_mem[rd_ptr_q];
      if (restart) begin
        count_q      <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        fetch_addr_q <= '0;
        epoch_q      <= ~epoch_q;
        underrun_q   <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (pop && !push) count_q <= count_q - CNT_W'(1);
        if (empty_pop) underrun_q <= 1'b1;
        if (fetch_gnt) fetch_addr_q <= fetch_addr_q + FA_W'(1);
      end
      if (!bus.enable)                                     state_q <= IDLE;
      else if (bus.frame_start)                            state_q <= FETCH;
      else if ((state_q == FETCH) && fetch_gnt &&
               (fetch_addr_q == FA_W'(FB_WORDS - 1)))     state_q <= DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.mem_rdata;
  end

`ifdef FB_ARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (bus.cpu_req && !cpu_gnt) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (empty_pop && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
`endif
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: fill, drain to underrun, CPU write/read,
// urgent-fetch priority, mid-frame restart and asynchronous reset.
module tb_fb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  logic [1:0] state;
  int n_cmp;
  int n_fail;
  logic [DATA_W-1:0] ram [256];

  fb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FB_ARB_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] underrun_cnt;
`endif

  fb_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(16),
    .FIFO_DEPTH(8), .LOW_WATER(2), .RD_LAT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_o(state)
`ifdef FB_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .underrun_cnt(underrun_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_init(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // synchronous RAM model, one-cycle read latency; reloaded while in reset
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.frame_start = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.pix_req = 1'b0;
    #1 reset = 1'b0;
    #2;
    // reset values
    check("rst_ctrl", {bus.cpu_ready, bus.cpu_rvalid, bus.pix_valid, bus.underrun, bus.mem_we}, 5'b0);
    check("rst_state", state, 2'd0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_pix_data", bus.pix_data, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    step;
    step;
    reset = 1'b1;
    step;

    // fill: fetches 0..7 then stop
    bus.enable = 1'b1;
    bus.frame_start = 1'b1;
    #1;
    check("fill_idle_state", state, 2'd0);
    step;
    bus.frame_start = 1'b0;
    #1;
    check("fill_fetch_state", state, 2'd1);
    for (int i = 0; i < 8; i++) begin
      check("fill_addr", bus.mem_addr, i);
      check("fill_we", bus.mem_we, 1'b0);
      step;
    end
    for (int i = 0; i < 3; i++) begin
      check("full_hold_addr", bus.mem_addr, 7);
      check("full_we", bus.mem_we, 1'b0);
      step;
    end

    // CPU write then read while FIFO full
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0040;
    bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    check("wr_ready", bus.cpu_ready, 1'b1);
    check("wr_we", bus.mem_we, 1'b1);
    check("wr_addr", bus.mem_addr, 16'h0040);
    check("wr_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step;
    bus.cpu_we = 1'b0;
    #1;
    check("rd_ready", bus.cpu_ready, 1'b1);
    check("rd_we", bus.mem_we, 1'b0);
    check("wr_no_rvalid", bus.cpu_rvalid, 1'b0);
    step;
    bus.cpu_req = 1'b0;
    #1;
    check("rd_rvalid", bus.cpu_rvalid, 1'b1);
    check("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    step;
    check("rd_rvalid_pulse", bus.cpu_rvalid, 1'b0);
    check("idle_hold_addr", bus.mem_addr, 16'h0040);

    // drain whole frame, then underrun
    bus.pix_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step;
      check("pop_valid", bus.pix_valid, 1'b1);
      check("pop_data", bus.pix_data, ram_init(k));
    end
    check("pre_underrun", bus.underrun, 1'b0);
    step;
    check("empty_valid", bus.pix_valid, 1'b0);
    check("empty_underrun", bus.underrun, 1'b1);
    check("empty_data_hold", bus.pix_data, ram_init(15));
    check("done_state", state, 2'd2);
    bus.pix_req = 1'b0;

    // new frame with CPU held: urgent fetch wins, then CPU
    bus.frame_start = 1'b1;
    #1;
    check("done_no_fetch", bus.mem_we, 1'b0);
    step;
    bus.frame_start = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0040;
    #1;
    check("urg1_ready", bus.cpu_ready, 1'b0);
    check("urg1_addr", bus.mem_addr, 0);
    check("restart_state", state, 2'd1);
    step;
    bus.pix_req = 1'b1;
    #1;
    check("urg2_ready", bus.cpu_ready, 1'b0);
    check("urg2_addr", bus.mem_addr, 1);
    step;
    bus.pix_req = 1'b0;
    #1;
    check("empty_pop_underrun", bus.underrun, 1'b1);
    check("empty_pop_valid", bus.pix_valid, 1'b0);
    check("cpu_grant", bus.cpu_ready, 1'b1);
    check("cpu_grant_addr", bus.mem_addr, 16'h0040);
    step;
    bus.cpu_req = 1'b0;
    #1;
    check("cpu2_rvalid", bus.cpu_rvalid, 1'b1);
    check("cpu2_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("refetch_addr", bus.mem_addr, 2);

    // restart with a fetch in flight
    step;
    bus.frame_start = 1'b1;
    #1;
    check("restart_no_fetch", bus.mem_addr, 2);
    check("restart_we", bus.mem_we, 1'b0);
    step;
    bus.frame_start = 1'b0;
    bus.pix_req = 1'b1;
    #1;
    check("restart_underrun_clr", bus.underrun, 1'b0);
    check("restart_addr0", bus.mem_addr, 0);
    step;
    bus.pix_req = 1'b0;
    #1;
    check("flushed_valid", bus.pix_valid, 1'b0);
    check("flushed_underrun", bus.underrun, 1'b1);
    check("flushed_data_hold", bus.pix_data, ram_init(15));
    check("restart_addr1", bus.mem_addr, 1);
    step;
    bus.pix_req = 1'b1;
    #1;
    check("restart_addr2", bus.mem_addr, 2);
    step;
    bus.pix_req = 1'b0;
    #1;
    check("new_frame_valid", bus.pix_valid, 1'b1);
    check("new_frame_data", bus.pix_data, ram_init(0));

    // async reset mid-FETCH with CPU request pending
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0010;
    bus.cpu_wdata = 32'h0000_1234;
    #1;
    check("pre_rst_ready", bus.cpu_ready, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_ctrl", {bus.cpu_ready, bus.cpu_rvalid, bus.pix_valid, bus.underrun, bus.mem_we}, 5'b0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_mem_wdata", bus.mem_wdata, 0);
    check("arst_pix_data", bus.pix_data, 0);
    check("arst_state", state, 2'd0);
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    step;
    step;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_state", state, 2'd0);
      check("post_rst_we", bus.mem_we, 1'b0);
      check("post_rst_addr", bus.mem_addr, 0);
      step;
    end
    bus.frame_start = 1'b1;
    step;
    bus.frame_start = 1'b0;
    #1;
    check("post_rst_fetch_state", state, 2'd1);
    check("post_rst_fetch_addr", bus.mem_addr, 0);
    step;
    check("post_rst_fetch_addr1", bus.mem_addr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
